vga_pixel_apb_writer: RTL and testbench
=======================================

Name: vga_pixel_apb_writer

Overview:
- APB master sitting directly upstream of the VGA framebuffer's APB slave port.
- Accepts single-pixel draw requests (x, y, 8-bit colour) over a valid/ready interface.
- Performs the framebuffer's required read-modify-write: read the 32-bit word holding 4 pixels, replace one byte lane, write the word back.
- Lets a CPU or drawing engine plot pixels without doing byte-lane merging in software.

Parameters:
- SCREEN_WIDTH, 640, pixels per line; also the framebuffer line stride in bytes.
- SCREEN_HEIGHT, 480, lines per frame.
- BASE_ADDR, 32'h0000_0000, APB address of pixel (0,0); must be 4-byte aligned.
- X_W, $clog2(SCREEN_WIDTH), width of pix_x_i (derived).
- Y_W, $clog2(SCREEN_HEIGHT), width of pix_y_i (derived).

Ports:
- clk_i  in  1  single clock; APB and request side share it.
- rstn_i  in  1  synchronous reset, active-low.
- pix_valid_i  in  1  draw request valid.
- pix_ready_o  out  1  block can accept a request.
- pix_x_i  in  X_W  pixel column.
- pix_y_i  in  Y_W  pixel row.
- pix_color_i  in  8  pixel colour byte.
- apb_paddr_o  out  32  APB address.
- apb_pwdata_o  out  32  APB write data.
- apb_pwrite_o  out  1  APB write select.
- apb_psel_o  out  1  APB select.
- apb_penable_o  out  1  APB enable.
- apb_prdata_i  in  32  APB read data.
- apb_pready_i  in  1  APB ready.
- apb_pslverr_i  in  1  APB slave error.
- busy_o  out  1  read-modify-write in progress.
- err_o  out  1  sticky slave-error flag.
- err_clr_i  in  1  clears err_o.
- oob_o  out  1  one-cycle pulse: an out-of-range request was dropped.

Behaviour:
- Reset: single clock, synchronous active-low reset; clock and reset ports are clk_i / rstn_i.
- While rstn_i=0, at each clk_i edge: state=IDLE; apb_psel_o, apb_penable_o, apb_pwrite_o, err_o, oob_o, busy_o = 0; apb_paddr_o, apb_pwdata_o = 0.
- pix_ready_o = (state==IDLE) && rstn_i, so it is 0 while reset is held.
- Handshake: a request is accepted on an edge where pix_valid_i && pix_ready_o. Inputs are sampled only then.
- Address arithmetic, computed at acceptance in 32-bit unsigned:
  - pn = y*SCREEN_WIDTH + x
  - addr = BASE_ADDR + {pn[31:2], 2'b00}
  - lane = pn[1:0]
  - addr, lane and colour are registered.
- Range check: a request with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT is accepted but dropped. oob_o pulses 1 in the following cycle, no APB activity occurs, and the state stays IDLE.
- State machine: IDLE -> RD_SETUP -> RD_ACCESS -> WR_SETUP -> WR_ACCESS -> IDLE.
- RD_SETUP (one cycle): psel=1, penable=0, pwrite=0, paddr=addr.
- RD_ACCESS: psel=1, penable=1.
  - Held while pready=0.
  - On the pready=1 edge, prdata is sampled.
  - If pslverr=1: set err_o and go to IDLE; no write is issued.
  - Otherwise: merged word = prdata with byte lane replaced by colour (lane0=[7:0] ... lane3=[31:24]); go to WR_SETUP.
- WR_SETUP (one cycle): psel=1, penable=0, pwrite=1, paddr=addr, pwdata=merged.
- WR_ACCESS: penable=1, held until pready=1. If pslverr=1 on that edge, set err_o. Then go to IDLE.
- psel and penable drop to 0 in the cycle after the completing edge; there are no back-to-back transfers.
- Signal stability: paddr, pwrite and pwdata are stable throughout each setup+access pair. pwdata keeps its last value outside writes.
- Latency: with zero wait states, the 4 APB cycles begin the cycle after acceptance, and pix_ready_o returns to 1 five cycles after the accepting edge. Each wait state adds one cycle.
- busy_o = (state != IDLE).
- err_o: a new error set wins over err_clr_i in the same cycle; otherwise err_clr_i clears it.
- Reset mid-operation: the transaction is abandoned; psel and penable are 0 after the reset edge and no write is issued.
- The slave must tolerate an abandoned access.

Decomposition:
- Package vga_pkg holds:
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults;
  - enum writer_state_t {IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS};
  - function merge_byte(word, lane, color).
- One combinational sub-module, vga_pix_addr: (x, y) -> addr, lane, oob. It is reusable by future fill/blit engines.

Test Plan:
1. (0,0,8'h5A); slave returns 32'h11223344 with zero wait states -> read @0x0, then write 32'h1122335A @0x0; pix_ready_o high again exactly 5 cycles after accept.
2. (3,1,8'hAB) with BASE_ADDR=32'h1000; prdata 32'hFFFFFFFF -> pn=643, paddr 32'h1280 for both phases, pwdata 32'hABFFFFFF.
3. Same as 1 with pready low for 3 cycles in RD_ACCESS and 2 cycles in WR_ACCESS -> paddr/pwrite/pwdata stable throughout, ready returns after 10 cycles.
4. pslverr=1 on read completion -> no WR_SETUP, err_o=1 and sticky across further good pixels until err_clr_i; err_clr_i coincident with a new error leaves err_o=1.
5. (640,0) then (0,480) -> oob_o pulses once for each, psel never asserted, pix_ready_o stays 1.
6. rstn_i low for one cycle during RD_ACCESS -> psel/penable 0 next cycle, no write phase; a new request is accepted after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, defaults and helpers for the VGA framebuffer pixel writers.
package vga_pkg;

   localparam int DEF_SCREEN_WIDTH  = 640;
   localparam int DEF_SCREEN_HEIGHT = 480;

   typedef enum logic [2:0] {
      IDLE,
      RD_SETUP,
      RD_ACCESS,
      WR_SETUP,
      WR_ACCESS
   } writer_state_t;

   // Replace one byte lane of a framebuffer word (lane 0 = bits [7:0]).
   function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  color);
      logic [31:0] r_word;
      r_word = word;
      case (lane)
         2'd0:    r_word[7:0]   = color;
         2'd1:    r_word[15:8]  = color;
         2'd2:    r_word[23:16] = color;
         default: r_word[31:24] = color;
      endcase
      return r_word;
   endfunction

endpackage

// File: rtl/vga_pix_addr.sv
// Pixel coordinate to framebuffer word address / byte lane, plus range check.
// Purely combinational so fill and blit engines can reuse it.
module vga_pix_addr
   import vga_pkg::*;
#(
   parameter int          SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int          SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          X_W           = $clog2(SCREEN_WIDTH),
   parameter int          Y_W           = $clog2(SCREEN_HEIGHT)
) (
   input  logic [X_W-1:0] i_x,
   input  logic [Y_W-1:0] i_y,
   output logic [31:0]    o_addr,
   output logic [1:0]     o_lane,
   output logic           o_oob
);

   logic [31:0] w_x32;
   logic [31:0] w_y32;
   logic [31:0] w_pn;

   assign w_x32 = {{(32-X_W){1'b0}}, i_x};
   assign w_y32 = {{(32-Y_W){1'b0}}, i_y};

   // Line stride equals the screen width in bytes (one byte per pixel).
   assign w_pn   = w_y32 * 32'(SCREEN_WIDTH) + w_x32;
   assign o_addr = BASE_ADDR + {w_pn[31:2], 2'b00};
   assign o_lane = w_pn[1:0];
   assign o_oob  = (w_x32 >= 32'(SCREEN_WIDTH)) || (w_y32 >= 32'(SCREEN_HEIGHT));

endmodule

// File: rtl/vga_pixel_apb_writer.sv
// APB master that plots single pixels into the VGA framebuffer using a
// read-modify-write of the 32-bit word holding four pixels.
module vga_pixel_apb_writer
   import vga_pkg::*;
#(
   parameter int          SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int          SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          X_W           = $clog2(SCREEN_WIDTH),
   parameter int          Y_W           = $clog2(SCREEN_HEIGHT)
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   input  logic           pix_valid_i,
   output logic           pix_ready_o,
   input  logic [X_W-1:0] pix_x_i,
   input  logic [Y_W-1:0] pix_y_i,
   input  logic [7:0]     pix_color_i,
   output logic [31:0]    apb_paddr_o,
   output logic [31:0]    apb_pwdata_o,
   output logic           apb_pwrite_o,
   output logic           apb_psel_o,
   output logic           apb_penable_o,
   input  logic [31:0]    apb_prdata_i,
   input  logic           apb_pready_i,
   input  logic           apb_pslverr_i,
   output logic           busy_o,
   output logic           err_o,
   input  logic           err_clr_i,
   output logic           oob_o
);

   writer_state_t r_state;
   writer_state_t w_state_nxt;

   logic [31:0] r_addr;
   logic [1:0]  r_lane;
   logic [7:0]  r_color;
   logic [31:0] r_pwdata;
   logic        r_err;
   logic        r_oob;

   logic [31:0] w_addr;
   logic [1:0]  w_lane;
   logic        w_oob;
   logic        w_accept;
   logic        w_rd_done;
   logic        w_err_set;

   vga_pix_addr #(
      .SCREEN_WIDTH  (SCREEN_WIDTH),
      .SCREEN_HEIGHT (SCREEN_HEIGHT),
      .BASE_ADDR     (BASE_ADDR),
      .X_W           (X_W),
      .Y_W           (Y_W)
   ) u_addr (
      .i_x    (pix_x_i),
      .i_y    (pix_y_i),
      .o_addr (w_addr),
      .o_lane (w_lane),
      .o_oob  (w_oob)
   );

   assign pix_ready_o = (r_state == IDLE) && rstn_i;
   assign w_accept    = pix_valid_i && pix_ready_o;
   assign w_rd_done   = (r_state == RD_ACCESS) && apb_pready_i && !apb_pslverr_i;
   assign w_err_set   = ((r_state == RD_ACCESS) || (r_state == WR_ACCESS)) &&
                        apb_pready_i && apb_pslverr_i;

   assign apb_paddr_o  = r_addr;
   assign apb_pwdata_o = r_pwdata;
   assign busy_o       = (r_state != IDLE);
   assign err_o        = r_err;
   assign oob_o        = r_oob;

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state and APB control strobes.
   always_comb begin
      w_state_nxt   = r_state;
      apb_psel_o    = 1'b0;
      apb_penable_o = 1'b0;
      apb_pwrite_o  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_oob) w_state_nxt = RD_SETUP;
         end
         RD_SETUP: begin
            apb_psel_o  = 1'b1;
            w_state_nxt = RD_ACCESS;
         end
         RD_ACCESS: begin
            apb_psel_o    = 1'b1;
            apb_penable_o = 1'b1;
            if (apb_pready_i) w_state_nxt = apb_pslverr_i ? IDLE : WR_SETUP;
         end
         WR_SETUP: begin
            apb_psel_o   = 1'b1;
            apb_pwrite_o = 1'b1;
            w_state_nxt  = WR_ACCESS;
         end
         WR_ACCESS: begin
            apb_psel_o    = 1'b1;
            apb_penable_o = 1'b1;
            apb_pwrite_o  = 1'b1;
            if (apb_pready_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture target word address, lane and colour when a drawable pixel is accepted.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_addr  <= 32'h0;
         r_lane  <= 2'd0;
         r_color <= 8'h0;
      end else if (w_accept && !w_oob) begin
         r_addr  <= w_addr;
         r_lane  <= w_lane;
         r_color <= pix_color_i;
      end
   end

   // Merged write word is built from the read data; it holds until the next read.
   always_ff @(posedge clk_i) begin
      if (!rstn_i)        r_pwdata <= 32'h0;
      else if (w_rd_done) r_pwdata <= merge_byte(apb_prdata_i, r_lane, r_color);
   end

   // Sticky slave-error flag (a new error beats a clear) and out-of-range pulse.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_err <= 1'b0;
         r_oob <= 1'b0;
      end else begin
         if (w_err_set)      r_err <= 1'b1;
         else if (err_clr_i) r_err <= 1'b0;
         r_oob <= w_accept && w_oob;
      end
   end

endmodule

// File: tb/tb_vga_pixel_apb_writer.sv
// Directed bench for vga_pixel_apb_writer; two instances differ only in BASE_ADDR.
module tb_vga_pixel_apb_writer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [7:0]  pix_color;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        err_clr;

   logic        ready0, pwrite0, psel0, penable0, busy0, err0, oob0;
   logic [31:0] paddr0, pwdata0;
   logic        ready1, pwrite1, psel1, penable1, busy1, err1, oob1;
   logic [31:0] paddr1, pwdata1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vga_pixel_apb_writer #(.BASE_ADDR(32'h0000_0000)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .pix_valid_i(pix_valid), .pix_ready_o(ready0),
      .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_color_i(pix_color),
      .apb_paddr_o(paddr0), .apb_pwdata_o(pwdata0), .apb_pwrite_o(pwrite0),
      .apb_psel_o(psel0), .apb_penable_o(penable0), .apb_prdata_i(prdata),
      .apb_pready_i(pready), .apb_pslverr_i(pslverr), .busy_o(busy0),
      .err_o(err0), .err_clr_i(err_clr), .oob_o(oob0));

   vga_pixel_apb_writer #(.BASE_ADDR(32'h0000_1000)) dut1 (
      .clk_i(clk), .rstn_i(rstn), .pix_valid_i(pix_valid), .pix_ready_o(ready1),
      .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_color_i(pix_color),
      .apb_paddr_o(paddr1), .apb_pwdata_o(pwdata1), .apb_pwrite_o(pwrite1),
      .apb_psel_o(psel1), .apb_penable_o(penable1), .apb_prdata_i(prdata),
      .apb_pready_i(pready), .apb_pslverr_i(pslverr), .busy_o(busy1),
      .err_o(err1), .err_clr_i(err_clr), .oob_o(oob1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One pixel through the full read-modify-write with a scripted slave.
   task automatic do_pix(input string nm, input logic [9:0] x, input logic [8:0] y,
                         input logic [7:0] c, input logic [31:0] rd,
                         input int rw, input int ww, input logic rerr, input logic werr,
                         input logic clr_at_end, input logic [31:0] ea,
                         input logic [31:0] ewd, input logic exp_err);
      pix_valid = 1'b1; pix_x = x; pix_y = y; pix_color = c;
      chk({nm, "_acc_ready"}, 32'(ready0), 32'd1);
      step();
      pix_valid = 1'b0;
      chk({nm, "_rs_psel"}, 32'(psel0), 32'd1);
      chk({nm, "_rs_pen"}, 32'(penable0), 32'd0);
      chk({nm, "_rs_pwrite"}, 32'(pwrite0), 32'd0);
      chk({nm, "_rs_paddr0"}, paddr0, ea);
      chk({nm, "_rs_paddr1"}, paddr1, ea + 32'h1000);
      chk({nm, "_rs_busy"}, 32'(busy0), 32'd1);
      chk({nm, "_rs_ready"}, 32'(ready0), 32'd0);
      step();
      for (int i = 0; i <= rw; i++) begin
         chk({nm, "_ra_psel"}, 32'(psel0), 32'd1);
         chk({nm, "_ra_pen"}, 32'(penable0), 32'd1);
         chk({nm, "_ra_pwrite"}, 32'(pwrite0), 32'd0);
         chk({nm, "_ra_paddr"}, paddr0, ea);
         chk({nm, "_ra_ready"}, 32'(ready0), 32'd0);
         prdata  = (i == rw) ? rd : 32'hDEAD_BEEF;
         pready  = (i == rw);
         pslverr = (i == rw) && rerr;
         step();
      end
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      if (rerr) begin
         chk({nm, "_re_psel"}, 32'(psel0), 32'd0);
         chk({nm, "_re_pen"}, 32'(penable0), 32'd0);
         chk({nm, "_re_busy"}, 32'(busy0), 32'd0);
         chk({nm, "_re_ready"}, 32'(ready0), 32'd1);
         chk({nm, "_re_err"}, 32'(err0), 32'(exp_err));
         step();
         chk({nm, "_re_nowrite"}, 32'(psel0), 32'd0);
         return;
      end
      chk({nm, "_ws_psel"}, 32'(psel0), 32'd1);
      chk({nm, "_ws_pen"}, 32'(penable0), 32'd0);
      chk({nm, "_ws_pwrite"}, 32'(pwrite0), 32'd1);
      chk({nm, "_ws_paddr0"}, paddr0, ea);
      chk({nm, "_ws_paddr1"}, paddr1, ea + 32'h1000);
      chk({nm, "_ws_pwdata0"}, pwdata0, ewd);
      chk({nm, "_ws_pwdata1"}, pwdata1, ewd);
      step();
      for (int i = 0; i <= ww; i++) begin
         chk({nm, "_wa_psel"}, 32'(psel0), 32'd1);
         chk({nm, "_wa_pen"}, 32'(penable0), 32'd1);
         chk({nm, "_wa_pwrite"}, 32'(pwrite0), 32'd1);
         chk({nm, "_wa_paddr"}, paddr0, ea);
         chk({nm, "_wa_pwdata"}, pwdata0, ewd);
         chk({nm, "_wa_ready"}, 32'(ready0), 32'd0);
         pready  = (i == ww);
         pslverr = (i == ww) && werr;
         err_clr = (i == ww) && clr_at_end;
         step();
      end
      pready = 1'b0; pslverr = 1'b0; err_clr = 1'b0;
      chk({nm, "_end_psel"}, 32'(psel0), 32'd0);
      chk({nm, "_end_pen"}, 32'(penable0), 32'd0);
      chk({nm, "_end_busy"}, 32'(busy0), 32'd0);
      chk({nm, "_end_ready"}, 32'(ready0), 32'd1);
      chk({nm, "_end_ready1"}, 32'(ready1), 32'd1);
      chk({nm, "_end_err"}, 32'(err0), 32'(exp_err));
      chk({nm, "_end_pwdata"}, pwdata0, ewd);
      chk({nm, "_end_oob"}, 32'(oob0), 32'd0);
   endtask

   task automatic do_oob(input string nm, input logic [9:0] x, input logic [8:0] y);
      pix_valid = 1'b1; pix_x = x; pix_y = y; pix_color = 8'hC3;
      chk({nm, "_ready"}, 32'(ready0), 32'd1);
      step();
      pix_valid = 1'b0;
      chk({nm, "_pulse"}, 32'(oob0), 32'd1);
      chk({nm, "_pulse1"}, 32'(oob1), 32'd1);
      chk({nm, "_psel"}, 32'(psel0), 32'd0);
      chk({nm, "_busy"}, 32'(busy0), 32'd0);
      chk({nm, "_ready_after"}, 32'(ready0), 32'd1);
      step();
      chk({nm, "_pulse_end"}, 32'(oob0), 32'd0);
      chk({nm, "_psel2"}, 32'(psel0), 32'd0);
   endtask

   initial begin
      rstn = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0; err_clr = 1'b0;
      repeat (3) step();
      chk("rst_psel", 32'(psel0), 32'd0);
      chk("rst_pen", 32'(penable0), 32'd0);
      chk("rst_pwrite", 32'(pwrite0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      chk("rst_oob", 32'(oob0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_paddr", paddr0, 32'h0);
      chk("rst_pwdata", pwdata0, 32'h0);
      chk("rst_ready", 32'(ready0), 32'd0);
      rstn = 1'b1;
      #1;
      chk("rel_ready", 32'(ready0), 32'd1);

      // Basic pixel, zero wait states.
      do_pix("t1", 10'd0, 9'd0, 8'h5A, 32'h1122_3344, 0, 0, 1'b0, 1'b0, 1'b0,
             32'h0, 32'h1122_335A, 1'b0);
      // pn=643 -> word 640, lane 3.
      do_pix("t2", 10'd3, 9'd1, 8'hAB, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0,
             32'h280, 32'hABFF_FFFF, 1'b0);
      // Wait states on both phases.
      do_pix("t3", 10'd0, 9'd0, 8'h5A, 32'h1122_3344, 3, 2, 1'b0, 1'b0, 1'b0,
             32'h0, 32'h1122_335A, 1'b0);
      // Read error: no write, sticky flag.
      do_pix("t4a", 10'd2, 9'd0, 8'h10, 32'h0, 1, 0, 1'b1, 1'b0, 1'b0,
             32'h0, 32'h0, 1'b1);
      do_pix("t4b", 10'd1, 9'd0, 8'h77, 32'hCAFE_BABE, 0, 0, 1'b0, 1'b0, 1'b0,
             32'h0, 32'hCAFE_77BE, 1'b1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t4_clr", 32'(err0), 32'd0);
      // pn=1285 -> word 1284, lane 1; write error coincides with clear.
      do_pix("t4c", 10'd5, 9'd2, 8'h99, 32'h0102_0304, 0, 1, 1'b0, 1'b1, 1'b1,
             32'h504, 32'h0102_9904, 1'b1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t4_clr2", 32'(err0), 32'd0);

      // Out-of-range requests.
      do_oob("t5x", 10'd640, 9'd0);
      do_oob("t5y", 10'd0, 9'd480);

      // Reset in the middle of the read access.
      pix_valid = 1'b1; pix_x = 10'd8; pix_y = 9'd0; pix_color = 8'h42;
      step();
      pix_valid = 1'b0;
      step();
      chk("t6_in_ra", 32'(penable0), 32'd1);
      rstn = 1'b0;
      step();
      chk("t6_psel", 32'(psel0), 32'd0);
      chk("t6_pen", 32'(penable0), 32'd0);
      chk("t6_busy", 32'(busy0), 32'd0);
      chk("t6_ready_low", 32'(ready0), 32'd0);
      rstn = 1'b1;
      step();
      chk("t6_nowrite", 32'(psel0), 32'd0);
      // Last pixel of the screen: pn=307199 -> word 307196, lane 3.
      do_pix("t6n", 10'd639, 9'd479, 8'hEE, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0,
             32'h0004_AFFC, 32'hEE00_0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
